// File: rtl/spi_flash_arb.sv
// Two-master arbiter for one SPI boot-flash port: whole-transaction grants with
// round-robin ties, a forced CS-high guard gap between owners and a per-grant watchdog.
module spi_flash_arb #(
    parameter int gap   = 4,
    parameter int tmo_w = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    input  logic m0_sclk,
    input  logic m0_cs,
    input  logic m0_mosi,
    input  logic m1_sclk,
    input  logic m1_cs,
    input  logic m1_mosi,
    output logic m0_miso,
    output logic m1_miso,
    output logic spi_clk,
    output logic spi_cs,
    output logic spi_mosi,
    input  logic spi_miso,
    input  logic err_clr,
    output logic timeout_err,
    output logic busy
);

    localparam int GW = (gap > 1) ? $clog2(gap) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(gap - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [tmo_w-1:0] wd_q, wd_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             lock0_q, lock0_d;
    logic             lock1_q, lock1_d;
    logic             err_q, err_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             elig0, elig1, revoke;

    assign elig0 = req0 & ~lock0_q;
    assign elig1 = req1 & ~lock1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            wd_q    <= '0;
            gap_q   <= '0;
            lock0_q <= 1'b0;
            lock1_q <= 1'b0;
            err_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            lock0_q <= lock0_d;
            lock1_q <= lock1_d;
            err_q   <= err_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    // Release is checked before the watchdog so a coinciding drop of req is not an error.
    always_comb begin
        state_d = state_q;
        revoke  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (elig0 && elig1) state_d = last_q ? ST_OWN0 : ST_OWN1;
                else if (elig0)     state_d = ST_OWN0;
                else if (elig1)     state_d = ST_OWN1;
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_d = ST_GAP;
                end else if (&wd_q) begin
                    state_d = ST_GAP;
                    revoke  = 1'b1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = ST_GAP;
                end else if (&wd_q) begin
                    state_d = ST_GAP;
                    revoke  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && state_d == ST_OWN0) last_d = 1'b0;
        if (state_q == ST_IDLE && state_d == ST_OWN1) last_d = 1'b1;

        wd_d  = ((state_q == ST_OWN0 || state_q == ST_OWN1) && state_d == state_q)
                ? wd_q + 1'b1 : '0;
        gap_d = (state_q == ST_GAP && state_d == ST_GAP) ? gap_q + 1'b1 : '0;

        lock0_d = lock0_q;
        if (revoke && state_q == ST_OWN0) lock0_d = 1'b1;
        if (!req0)                        lock0_d = 1'b0;
        lock1_d = lock1_q;
        if (revoke && state_q == ST_OWN1) lock1_d = 1'b1;
        if (!req1)                        lock1_d = 1'b0;

        if (revoke)       err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;

        // Pins follow the owner only while it keeps the grant; any hand-off edge idles them.
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        if (state_q == ST_OWN0 && state_d == ST_OWN0) begin
            sclk_d = m0_sclk;
            cs_d   = m0_cs;
            mosi_d = m0_mosi;
        end else if (state_q == ST_OWN1 && state_d == ST_OWN1) begin
            sclk_d = m1_sclk;
            cs_d   = m1_cs;
            mosi_d = m1_mosi;
        end
    end

    always_comb begin
        gnt0        = (state_q == ST_OWN0);
        gnt1        = (state_q == ST_OWN1);
        busy        = (state_q != ST_IDLE);
        m0_miso     = gnt0 & spi_miso;
        m1_miso     = gnt1 & spi_miso;
        spi_clk     = sclk_q;
        spi_cs      = cs_q;
        spi_mosi    = mosi_q;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_spi_flash_arb.sv
// Bench for spi_flash_arb: an ownership/countdown model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_spi_flash_arb;

    localparam int GAP   = 4;
    localparam int TMO_W = 4;

    logic clk = 1'b0;
    logic rst_n, req0, req1, err_clr, spi_miso;
    logic m0_sclk, m0_cs, m0_mosi, m1_sclk, m1_cs, m1_mosi;
    logic gnt0, gnt1, m0_miso, m1_miso, spi_clk, spi_cs, spi_mosi, timeout_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    spi_flash_arb #(.gap(GAP), .tmo_w(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1),
        .m0_sclk(m0_sclk), .m0_cs(m0_cs), .m0_mosi(m0_mosi),
        .m1_sclk(m1_sclk), .m1_cs(m1_cs), .m1_mosi(m1_mosi),
        .m0_miso(m0_miso), .m1_miso(m1_miso),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .err_clr(err_clr), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: who owns the port, how long it has owned it, and how many guard cycles remain.
    int md_own, md_held, md_gap_left, md_last;
    bit md_lock0, md_lock1, md_err, md_clk, md_cs, md_mosi;
    bit md_e0, md_e1, md_tmo, md_rq;

    always @(posedge clk) begin
        if (!rst_n) begin
            md_own = -1; md_held = 0; md_gap_left = 0; md_last = 1;
            md_lock0 = 0; md_lock1 = 0; md_err = 0;
            md_clk = 0; md_cs = 1; md_mosi = 0;
        end else begin
            md_e0 = req0 && !md_lock0;
            md_e1 = req1 && !md_lock1;
            md_tmo = 0;
            md_clk = 0; md_cs = 1; md_mosi = 0;
            if (md_own >= 0) begin
                md_rq = (md_own == 0) ? req0 : req1;
                if (!md_rq) begin
                    md_own = -1;
                    md_gap_left = GAP;
                end else if (md_held == (1 << TMO_W)) begin
                    md_tmo = 1;
                    if (md_own == 0) md_lock0 = 1; else md_lock1 = 1;
                    md_own = -1;
                    md_gap_left = GAP;
                end else begin
                    md_held++;
                    if (md_own == 0) begin md_clk = m0_sclk; md_cs = m0_cs; md_mosi = m0_mosi; end
                    else begin md_clk = m1_sclk; md_cs = m1_cs; md_mosi = m1_mosi; end
                end
            end else if (md_gap_left > 0) begin
                md_gap_left--;
            end else begin
                if (md_e0 && md_e1) md_own = (md_last == 0) ? 1 : 0;
                else if (md_e0)     md_own = 0;
                else if (md_e1)     md_own = 1;
                if (md_own >= 0) begin md_last = md_own; md_held = 1; end
            end
            if (!req0) md_lock0 = 0;
            if (!req1) md_lock1 = 0;
            if (md_tmo)       md_err = 1;
            else if (err_clr) md_err = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_gnt0", gnt0, md_own == 0);
            check("cyc_gnt1", gnt1, md_own == 1);
            check("cyc_busy", busy, (md_own >= 0) || (md_gap_left > 0));
            check("cyc_err", timeout_err, md_err);
            check("cyc_spi_clk", spi_clk, md_clk);
            check("cyc_spi_cs", spi_cs, md_cs);
            check("cyc_spi_mosi", spi_mosi, md_mosi);
            check("cyc_m0_miso", m0_miso, (md_own == 0) && spi_miso);
            check("cyc_m1_miso", m1_miso, (md_own == 1) && spi_miso);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 0; req0 = 0; req1 = 0; err_clr = 0; spi_miso = 0;
        m0_sclk = 0; m0_cs = 1; m0_mosi = 0;
        m1_sclk = 0; m1_cs = 1; m1_mosi = 0;
        tick(2);
        chk_en = 1'b1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_spi_cs", spi_cs, 1'b1);
        check("rst_spi_clk", spi_clk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", timeout_err, 1'b0);
        rst_n = 1;
        tick(1);

        // Single owner, pin lag, m1 isolation, abort on release with cs still low
        req0 = 1;
        tick(1);
        check("t1_gnt0", gnt0, 1'b1);
        check("t1_busy", busy, 1'b1);
        m0_cs = 0;
        tick(1);
        check("t1_cs_lag", spi_cs, 1'b0);
        spi_miso = 1;
        for (int i = 0; i < 6; i++) begin
            m0_sclk = ~m0_sclk;
            m0_mosi = 1'($urandom);
            m1_sclk = 1'($urandom);
            m1_mosi = 1'($urandom);
            m1_cs   = 1'($urandom);
            tick(1);
            check("t6_mosi", spi_mosi, m0_mosi);
            check("t6_m1_miso", m1_miso, 1'b0);
            check("t6_m0_miso", m0_miso, 1'b1);
        end
        m0_sclk = 0; m1_sclk = 0; m1_mosi = 0; m1_cs = 1;
        req0 = 0;
        tick(1);
        check("t1_rel_gnt0", gnt0, 1'b0);
        check("t1_rel_cs", spi_cs, 1'b1);
        check("t1_rel_clk", spi_clk, 1'b0);
        m0_cs = 1;
        tick(3);
        check("t1_gap_cs", spi_cs, 1'b1);
        check("t1_gap_busy", busy, 1'b1);
        tick(1);
        check("t1_idle_busy", busy, 1'b0);

        // Tie after reset, guard gap length, round-robin
        rst_n = 0;
        tick(1);
        rst_n = 1;
        req0 = 1; req1 = 1;
        tick(1);
        check("t2_tie_gnt0", gnt0, 1'b1);
        check("t2_tie_gnt1", gnt1, 1'b0);
        tick(3);
        req0 = 0;
        tick(1);
        check("t2_rel_gnt0", gnt0, 1'b0);
        n = 0;
        while (gnt1 !== 1'b1 && n < 20) begin tick(1); n++; end
        check_int("t2_gap_len", n, GAP + 1);
        req0 = 1;
        tick(2);
        check("t2_hold_gnt1", gnt1, 1'b1);
        req1 = 0;
        tick(1);
        req1 = 1;
        n = 0;
        while (gnt0 !== 1'b1 && gnt1 !== 1'b1 && n < 20) begin tick(1); n++; end
        check("t2_rr_gnt0", gnt0, 1'b1);
        check("t2_rr_gnt1", gnt1, 1'b0);
        req0 = 0; req1 = 0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(1); n++; end
        check("t2_idle", busy, 1'b0);

        // Watchdog revoke with err_clr in the same cycle
        req0 = 1;
        tick(1);
        check("t3_gnt0", gnt0, 1'b1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            err_clr = (n == (1 << TMO_W));
            tick(1);
            err_clr = 0;
            if (gnt0 === 1'b1) n++;
            else break;
        end
        check_int("t3_owned", n, 16);
        check("t4_set_wins", timeout_err, 1'b1);
        check("t3_tmo_cs", spi_cs, 1'b1);
        check("t3_tmo_gnt0", gnt0, 1'b0);
        tick(8);
        check("t3_locked", gnt0, 1'b0);
        req1 = 1;
        tick(1);
        check("t3_gnt1", gnt1, 1'b1);
        m1_cs = 0;
        for (int i = 0; i < 3; i++) begin
            m1_sclk = ~m1_sclk;
            m1_mosi = 1'($urandom);
            m0_sclk = 1'($urandom);
            spi_miso = 1'($urandom);
            tick(1);
        end
        m1_sclk = 0; m0_sclk = 0;
        err_clr = 1;
        tick(1);
        err_clr = 0;
        check("t4_cleared", timeout_err, 1'b0);
        req0 = 0;
        tick(1);
        req0 = 1;
        tick(1);
        check("t3_m1_keeps", gnt1, 1'b1);
        m1_cs = 1;
        req1 = 0;
        n = 0;
        while (gnt0 !== 1'b1 && n < 20) begin tick(1); n++; end
        check("t3_regrant0", gnt0, 1'b1);
        req0 = 0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(1); n++; end

        // Reset mid-OWN1 with cs low, after a fresh timeout on m0
        req0 = 1;
        tick(18);
        check("t5_err_set", timeout_err, 1'b1);
        req1 = 1;
        n = 0;
        while (gnt1 !== 1'b1 && n < 20) begin tick(1); n++; end
        check("t5_gnt1", gnt1, 1'b1);
        m1_cs = 0;
        tick(2);
        check("t5_cs_own", spi_cs, 1'b0);
        m1_sclk = 1;
        tick(1);
        rst_n = 0;
        tick(1);
        check("t5_rst_cs", spi_cs, 1'b1);
        check("t5_rst_clk", spi_clk, 1'b0);
        check("t5_rst_gnt1", gnt1, 1'b0);
        check("t5_rst_err", timeout_err, 1'b0);
        rst_n = 1;
        m1_cs = 1; m1_sclk = 0;
        tick(1);
        check("t5_tie_gnt0", gnt0, 1'b1);
        check("t5_tie_gnt1", gnt1, 1'b0);
        req0 = 0; req1 = 0;
        tick(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
